// File: rtl/rv32imf_apu_router.sv
// Routes core APU requests to NUM_UNITS units by opcode field, returning results in issue order (1-cycle latency, grant is combinational).
// Core is held off only when DEPTH ops are in flight; units are never back-pressured. RV32IMF_APU_ROUTER_BYPASS_EN enables 0-cycle head return.

module rv32imf_apu_router_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_i);
    cnt_d    = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign empty_o    = (cnt_q == '0);
endmodule

module rv32imf_apu_router #(
  parameter int NUM_UNITS = 2,
  parameter int DEPTH     = 4,
  parameter int NARGS     = 3,
  parameter int WOP       = 6,
  parameter int NDSFLAGS  = 15,
  parameter int NUSFLAGS  = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                apu_req_i,
  output logic                                apu_gnt_o,
  input  logic [NARGS-1:0][31:0]              apu_operands_i,
  input  logic [WOP-1:0]                      apu_op_i,
  input  logic [NDSFLAGS-1:0]                 apu_flags_i,
  output logic                                apu_rvalid_o,
  output logic [31:0]                         apu_result_o,
  output logic [NUSFLAGS-1:0]                 apu_rflags_o,
  output logic                                apu_busy_o,
  output logic [NUM_UNITS-1:0]                unit_req_o,
  input  logic [NUM_UNITS-1:0]                unit_gnt_i,
  output logic [NARGS-1:0][31:0]              unit_operands_o,
  output logic [WOP-1:0]                      unit_op_o,
  output logic [NDSFLAGS-1:0]                 unit_flags_o,
  input  logic [NUM_UNITS-1:0]                unit_rvalid_i,
  input  logic [NUM_UNITS-1:0][31:0]          unit_rdata_i,
  input  logic [NUM_UNITS-1:0][NUSFLAGS-1:0]  unit_rflags_i,
  output logic [NUM_UNITS-1:0]                unit_clk_en_o
);
  localparam int SEL_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 0;
  localparam int SEL_EW = (SEL_W > 0) ? SEL_W : 1;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int RW     = 32 + NUSFLAGS;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [NUSFLAGS-1:0] rflags;
  } res_t;

  logic [SEL_EW-1:0]    sel, ord_head;
  logic                 full, gnt, ord_empty, pop_rf, byp, ret;
  logic [NUM_UNITS-1:0] cap, rf_empty, rf_push, rf_pop;
  res_t                 rf_head [NUM_UNITS];
  res_t                 ret_dat;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [CW-1:0]        inflight_q [NUM_UNITS];
  logic [CW-1:0]        inflight_d [NUM_UNITS];

  assign unit_operands_o = apu_operands_i;
  assign unit_op_o       = apu_op_i;
  assign unit_flags_o    = apu_flags_i;

  // Out-of-range unit indices fall back to unit 0
  if (SEL_W == 0) begin : g_sel_one
    assign sel = 1'b0;
  end else begin : g_sel
    logic [SEL_W-1:0] raw;
    assign raw = apu_op_i[WOP-1 -: SEL_W];
    assign sel = ({1'b0, raw} >= (SEL_W+1)'(NUM_UNITS)) ? '0 : raw;
  end

  assign full = (out_cnt_q == CW'(DEPTH));

  always_comb begin
    unit_req_o      = '0;
    unit_req_o[sel] = apu_req_i & ~full;
  end

  assign gnt = unit_req_o[sel] & unit_gnt_i[sel];
  assign apu_gnt_o = gnt;

  rv32imf_apu_router_fifo #(.W(SEL_EW), .DEPTH(DEPTH)) u_order (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (gnt),
    .push_dat_i (sel),
    .pop_i      (ret),
    .head_dat_o (ord_head),
    .empty_o    (ord_empty)
  );

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    // Results with no matching outstanding op (e.g. after a reset) are dropped
    assign cap[g]     = unit_rvalid_i[g] & (inflight_q[g] != '0);
    assign rf_push[g] = cap[g] & ~(byp & (ord_head == SEL_EW'(g)));
    assign rf_pop[g]  = pop_rf & (ord_head == SEL_EW'(g));
    assign unit_clk_en_o[g] = unit_req_o[g] | (inflight_q[g] != '0);

    rv32imf_apu_router_fifo #(.W(RW), .DEPTH(DEPTH)) u_res (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (rf_push[g]),
      .push_dat_i ({unit_rdata_i[g], unit_rflags_i[g]}),
      .pop_i      (rf_pop[g]),
      .head_dat_o (rf_head[g]),
      .empty_o    (rf_empty[g])
    );
  end

  assign pop_rf = ~ord_empty & ~rf_empty[ord_head];
`ifdef RV32IMF_APU_ROUTER_BYPASS_EN
  assign byp = ~ord_empty & rf_empty[ord_head] & cap[ord_head];
`else
  assign byp = 1'b0;
`endif
  assign ret = pop_rf | byp;

  always_comb begin
    ret_dat = '0;
    if (byp) ret_dat = '{rdata: unit_rdata_i[ord_head], rflags: unit_rflags_i[ord_head]};
    else if (pop_rf) ret_dat = rf_head[ord_head];
  end

  assign apu_rvalid_o = ret;
  assign apu_result_o = ret_dat.rdata;
  assign apu_rflags_o = ret_dat.rflags;
  assign apu_busy_o   = (out_cnt_q != '0);

  always_comb begin
    out_cnt_d = out_cnt_q + CW'(gnt) - CW'(ret);
    for (int i = 0; i < NUM_UNITS; i++) begin
      inflight_d[i] = inflight_q[i] + CW'(gnt && (sel == SEL_EW'(i))) - CW'(cap[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) inflight_q[i] <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      for (int i = 0; i < NUM_UNITS; i++) inflight_q[i] <= inflight_d[i];
    end
  end
endmodule

// File: tb/tb_rv32imf_apu_router.sv
// Directed bench for rv32imf_apu_router with three units and four in-flight slots.
// Per-cycle vector table plus hand sequences for full, reset and return latency.

module tb_rv32imf_apu_router;
  localparam int NU = 3;
`ifdef RV32IMF_APU_ROUTER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 apu_req_i;
  logic                 apu_gnt_o;
  logic [2:0][31:0]     apu_operands_i;
  logic [5:0]           apu_op_i;
  logic [14:0]          apu_flags_i;
  logic                 apu_rvalid_o;
  logic [31:0]          apu_result_o;
  logic [4:0]           apu_rflags_o;
  logic                 apu_busy_o;
  logic [NU-1:0]        unit_req_o;
  logic [NU-1:0]        unit_gnt_i;
  logic [2:0][31:0]     unit_operands_o;
  logic [5:0]           unit_op_o;
  logic [14:0]          unit_flags_o;
  logic [NU-1:0]        unit_rvalid_i;
  logic [31:0]          rdata;
  logic [4:0]           rflags;
  logic [NU-1:0][31:0]  unit_rdata_i;
  logic [NU-1:0][4:0]   unit_rflags_i;
  logic [NU-1:0]        unit_clk_en_o;

  assign unit_rdata_i  = {NU{rdata}};
  assign unit_rflags_i = {NU{rflags}};

  always #5 clk_i = ~clk_i;

  rv32imf_apu_router #(.NUM_UNITS(NU), .DEPTH(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .apu_req_i       (apu_req_i),
    .apu_gnt_o       (apu_gnt_o),
    .apu_operands_i  (apu_operands_i),
    .apu_op_i        (apu_op_i),
    .apu_flags_i     (apu_flags_i),
    .apu_rvalid_o    (apu_rvalid_o),
    .apu_result_o    (apu_result_o),
    .apu_rflags_o    (apu_rflags_o),
    .apu_busy_o      (apu_busy_o),
    .unit_req_o      (unit_req_o),
    .unit_gnt_i      (unit_gnt_i),
    .unit_operands_o (unit_operands_o),
    .unit_op_o       (unit_op_o),
    .unit_flags_o    (unit_flags_o),
    .unit_rvalid_i   (unit_rvalid_i),
    .unit_rdata_i    (unit_rdata_i),
    .unit_rflags_i   (unit_rflags_i),
    .unit_clk_en_o   (unit_clk_en_o)
  );

  typedef struct {
    logic        req;
    logic [5:0]  op;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic [31:0] rd;
    logic [4:0]  rf;
    logic [2:0]  e_ureq;
    logic        e_gnt;
    logic        e_rv;
    logic [31:0] e_res;
    logic [4:0]  e_rfl;
    logic        e_busy;
    logic [2:0]  e_cken;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t v(input logic req, input logic [5:0] op, input logic [2:0] g,
                             input logic [2:0] rv, input logic [31:0] rd, input logic [4:0] rf,
                             input logic [2:0] eu, input logic eg, input logic erv,
                             input logic [31:0] er, input logic [4:0] erf, input logic eb,
                             input logic [2:0] ec);
    vec_t t;
    t.req = req; t.op = op; t.gnt = g; t.rv = rv; t.rd = rd; t.rf = rf;
    t.e_ureq = eu; t.e_gnt = eg; t.e_rv = erv; t.e_res = er; t.e_rfl = erf;
    t.e_busy = eb; t.e_cken = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [5:0] op, input logic [2:0] g,
                       input logic [2:0] rv, input logic [31:0] rd, input logic [4:0] rf);
    apu_req_i = req; apu_op_i = op; unit_gnt_i = g;
    unit_rvalid_i = rv; rdata = rd; rflags = rf;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Single op, out-of-order pair, spurious rvalid, out-of-range select,
    // issue+return same cycle, grant+capture on the same unit.
    tbl[0]  = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  0, 3'b000);
    tbl[1]  = v(1, 6'h00, 3'b001, 3'b000, 32'h0,        5'h0,  3'b001, 1, 0, 32'h0,        5'h0,  0, 3'b001);
    tbl[2]  = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  1, 3'b001);
    tbl[3]  = v(0, 6'h00, 3'b000, 3'b001, 32'h3F800000, 5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  1, 3'b001);
    tbl[4]  = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 1, 32'h3F800000, 5'h0,  1, 3'b000);
    tbl[5]  = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  0, 3'b000);
    tbl[6]  = v(1, 6'h10, 3'b010, 3'b000, 32'h0,        5'h0,  3'b010, 1, 0, 32'h0,        5'h0,  0, 3'b010);
    tbl[7]  = v(1, 6'h05, 3'b001, 3'b000, 32'h0,        5'h0,  3'b001, 1, 0, 32'h0,        5'h0,  1, 3'b011);
    tbl[8]  = v(0, 6'h00, 3'b000, 3'b001, 32'hB,        5'h1,  3'b000, 0, 0, 32'h0,        5'h0,  1, 3'b011);
    tbl[9]  = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  1, 3'b010);
    tbl[10] = v(0, 6'h00, 3'b000, 3'b010, 32'hA,        5'h2,  3'b000, 0, 0, 32'h0,        5'h0,  1, 3'b010);
    tbl[11] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 1, 32'hA,        5'h2,  1, 3'b000);
    tbl[12] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 1, 32'hB,        5'h1,  1, 3'b000);
    tbl[13] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  0, 3'b000);
    tbl[14] = v(0, 6'h00, 3'b000, 3'b100, 32'h55,       5'h7,  3'b000, 0, 0, 32'h0,        5'h0,  0, 3'b000);
    tbl[15] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  0, 3'b000);
    tbl[16] = v(1, 6'h30, 3'b001, 3'b000, 32'h0,        5'h0,  3'b001, 1, 0, 32'h0,        5'h0,  0, 3'b001);
    tbl[17] = v(1, 6'h20, 3'b000, 3'b000, 32'h0,        5'h0,  3'b100, 0, 0, 32'h0,        5'h0,  1, 3'b101);
    tbl[18] = v(1, 6'h20, 3'b100, 3'b001, 32'h77,       5'h3,  3'b100, 1, 0, 32'h0,        5'h0,  1, 3'b101);
    tbl[19] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 1, 32'h77,       5'h3,  1, 3'b100);
    tbl[20] = v(1, 6'h00, 3'b001, 3'b100, 32'h99,       5'h4,  3'b001, 1, 0, 32'h0,        5'h0,  1, 3'b101);
    tbl[21] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 1, 32'h99,       5'h4,  1, 3'b001);
    tbl[22] = v(1, 6'h10, 3'b010, 3'b001, 32'h11,       5'h1F, 3'b010, 1, 0, 32'h0,        5'h0,  1, 3'b011);
    tbl[23] = v(1, 6'h10, 3'b010, 3'b000, 32'h0,        5'h0,  3'b010, 1, 1, 32'h11,       5'h1F, 1, 3'b010);
    tbl[24] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  1, 3'b010);
    tbl[25] = v(1, 6'h10, 3'b010, 3'b010, 32'h21,       5'h0,  3'b010, 1, 0, 32'h0,        5'h0,  1, 3'b010);
    tbl[26] = v(0, 6'h00, 3'b000, 3'b010, 32'h22,       5'h0,  3'b000, 0, 1, 32'h21,       5'h0,  1, 3'b010);
    tbl[27] = v(0, 6'h00, 3'b000, 3'b010, 32'h23,       5'h0,  3'b000, 0, 1, 32'h22,       5'h0,  1, 3'b010);
    tbl[28] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 1, 32'h23,       5'h0,  1, 3'b000);
    tbl[29] = v(0, 6'h00, 3'b000, 3'b000, 32'h0,        5'h0,  3'b000, 0, 0, 32'h0,        5'h0,  0, 3'b000);

    rst_ni = 1'b0;
    apu_operands_i = {32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    apu_flags_i = 15'h1234;
    drive(0, 6'h00, 3'b000, 3'b000, 32'h0, 5'h0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.busy",   32'(apu_busy_o),    32'h0);
    chk("rst.rvalid", 32'(apu_rvalid_o),  32'h0);
    chk("rst.cken",   32'(unit_clk_en_o), 32'h0);
    chk("rst.ureq",   32'(unit_req_o),    32'h0);
    chk("bcast.operands", unit_operands_o[2], 32'hC0DE0002);
    chk("bcast.flags",    32'(unit_flags_o),  32'h1234);
    rst_ni = 1'b1;

`ifndef RV32IMF_APU_ROUTER_BYPASS_EN
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].req, tbl[i].op, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].rf);
      @(negedge clk_i);
      chk($sformatf("row%0d.ureq", i),   32'(unit_req_o),    32'(tbl[i].e_ureq));
      chk($sformatf("row%0d.gnt", i),    32'(apu_gnt_o),     32'(tbl[i].e_gnt));
      chk($sformatf("row%0d.rvalid", i), 32'(apu_rvalid_o),  32'(tbl[i].e_rv));
      chk($sformatf("row%0d.result", i), apu_result_o,       tbl[i].e_res);
      chk($sformatf("row%0d.rflags", i), 32'(apu_rflags_o),  32'(tbl[i].e_rfl));
      chk($sformatf("row%0d.busy", i),   32'(apu_busy_o),    32'(tbl[i].e_busy));
      chk($sformatf("row%0d.cken", i),   32'(unit_clk_en_o), 32'(tbl[i].e_cken));
      chk($sformatf("row%0d.op", i),     32'(unit_op_o),     32'(tbl[i].op));
      step();
    end

    // Fill all four slots, then show a return frees a slot only next cycle
    for (int k = 0; k < 4; k++) begin
      drive(1, 6'h00, 3'b001, 3'b000, 32'h0, 5'h0);
      @(negedge clk_i);
      chk($sformatf("full.issue%0d", k), 32'(apu_gnt_o), 32'h1);
      step();
    end
    drive(1, 6'h00, 3'b001, 3'b001, 32'h100, 5'h0);
    @(negedge clk_i);
    chk("full.gnt",  32'(apu_gnt_o),  32'h0);
    chk("full.ureq", 32'(unit_req_o), 32'h0);
    chk("full.busy", 32'(apu_busy_o), 32'h1);
    step();
    drive(1, 6'h00, 3'b001, 3'b000, 32'h0, 5'h0);
    @(negedge clk_i);
    chk("full.ret.rvalid", 32'(apu_rvalid_o), 32'h1);
    chk("full.ret.result", apu_result_o,      32'h100);
    chk("full.ret.gnt",    32'(apu_gnt_o),    32'h0);
    step();
    @(negedge clk_i);
    chk("full.after.gnt",  32'(apu_gnt_o),  32'h1);
    chk("full.after.ureq", 32'(unit_req_o), 32'h1);
    step();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 6'h00, 3'b000, 3'b001, 32'h100 + 32'(k), 5'h0);
      @(negedge clk_i);
      chk($sformatf("drain%0d.rvalid", k), 32'(apu_rvalid_o), (k == 1) ? 32'h0 : 32'h1);
      chk($sformatf("drain%0d.result", k), apu_result_o, (k == 1) ? 32'h0 : 32'h100 + 32'(k - 1));
      step();
    end
    drive(0, 6'h00, 3'b000, 3'b000, 32'h0, 5'h0);
    @(negedge clk_i);
    chk("drain.last.result", apu_result_o, 32'h104);
    step();
    @(negedge clk_i);
    chk("drain.busy", 32'(apu_busy_o), 32'h0);
    step();
`endif

    // Reset with two ops outstanding; late results must vanish
    drive(1, 6'h00, 3'b001, 3'b000, 32'h0, 5'h0);
    step();
    drive(1, 6'h10, 3'b010, 3'b000, 32'h0, 5'h0);
    step();
    drive(0, 6'h00, 3'b000, 3'b000, 32'h0, 5'h0);
    @(negedge clk_i);
    chk("mrst.busy.before", 32'(apu_busy_o), 32'h1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mrst.busy",   32'(apu_busy_o),    32'h0);
    chk("mrst.rvalid", 32'(apu_rvalid_o),  32'h0);
    chk("mrst.cken",   32'(unit_clk_en_o), 32'h0);
    chk("mrst.gnt",    32'(apu_gnt_o),     32'h0);
    step();
    rst_ni = 1'b1;
    drive(0, 6'h00, 3'b000, 3'b011, 32'hDEAD, 5'h1);
    @(negedge clk_i);
    chk("late.rvalid", 32'(apu_rvalid_o),  32'h0);
    chk("late.busy",   32'(apu_busy_o),    32'h0);
    chk("late.cken",   32'(unit_clk_en_o), 32'h0);
    step();
    drive(0, 6'h00, 3'b000, 3'b000, 32'h0, 5'h0);
    @(negedge clk_i);
    chk("late.next.rvalid", 32'(apu_rvalid_o), 32'h0);
    chk("late.next.result", apu_result_o,      32'h0);
    step();

    // Return latency for a single op on unit 2
    drive(1, 6'h20, 3'b100, 3'b000, 32'h0, 5'h0);
    @(negedge clk_i);
    chk("lat.gnt", 32'(apu_gnt_o), 32'h1);
    step();
    drive(0, 6'h00, 3'b000, 3'b000, 32'h0, 5'h0);
    step();
    drive(0, 6'h00, 3'b000, 3'b100, 32'hCAFE, 5'h2);
    @(negedge clk_i);
    chk("lat.t0.rvalid", 32'(apu_rvalid_o), 32'(BYP));
    chk("lat.t0.result", apu_result_o, BYP ? 32'hCAFE : 32'h0);
    step();
    drive(0, 6'h00, 3'b000, 3'b000, 32'h0, 5'h0);
    @(negedge clk_i);
    chk("lat.t1.rvalid", 32'(apu_rvalid_o), 32'(!BYP));
    chk("lat.t1.result", apu_result_o, BYP ? 32'h0 : 32'hCAFE);
    chk("lat.t1.rflags", 32'(apu_rflags_o), BYP ? 32'h0 : 32'h2);
    step();
    @(negedge clk_i);
    chk("lat.busy", 32'(apu_busy_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
